fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller. Owns the program counter and drives the synchronous instruction ROM (Inst_ROM: 1-cycle read latency, word-addressed).
- Presents each instruction to decode with its PC and a valid flag.
- Handles downstream stall, branch/jump redirect, halt/resume, and counts fetched instructions.
- Sits between Inst_ROM and the decode stage.

Parameters:
- ADDR_W, 6, ROM word-address width; byte PC width is ADDR_W+2.
- RESET_PC, 0, byte PC loaded on reset; must be word-aligned.
- CNT_W, 16, width of fetch_count.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  decode cannot accept the current instruction
- br_taken  input  1  relative branch redirect
- br_offset  input  16  signed word offset for the branch
- jmp  input  1  absolute jump redirect
- jmp_target  input  26  word-address jump target
- halt_req  input  1  request to stop fetching
- resume  input  1  leave HALT
- rom_addr  output  ADDR_W  address to Inst_ROM addra (combinational)
- rom_data  input  32  Inst_ROM douta
- inst_code  output  32  instruction to decode; equals rom_data
- inst_pc  output  32  byte PC of inst_code; bits above ADDR_W+2 are always 0
- inst_valid  output  1  inst_code/inst_pc are meaningful
- halted  output  1  FSM is in HALT
- fetch_count  output  CNT_W  number of accepted instructions

Behaviour:
- PC register always holds the address of the word currently on rom_data. Next-PC (npc) is combinational; rom_addr = npc[ADDR_W+1:2]; PC <= npc each edge. Result: inst_code is aligned with inst_pc in every cycle, with zero-bubble sequential fetch.
- npc priority, highest first:
  - rst: RESET_PC
  - jmp: {jmp_target,2'b00} truncated to ADDR_W+2 bits
  - br_taken: PC + 4 + (sext(br_offset)<<2), mod 2^(ADDR_W+2)
  - HALT state, halt_req accepted, or (stall and inst_valid): PC
  - otherwise: PC+4, mod 2^(ADDR_W+2); 0xFC wraps to 0x00 at ADDR_W=6
- jmp and br_taken together: jmp wins. Redirect wins over stall; the stalled instruction is dropped and not counted.
- FSM states:
  - RESET: entered while rst=1. Drives PC=RESET_PC, inst_valid=0, halted=0, fetch_count=0.
  - RUN: entered on the first edge with rst=0. inst_valid=1 in every RUN cycle, including the first.
  - HALT: inst_valid=0, halted=1, PC frozen. rom_addr=PC, so rom_data stays ROM[PC].
- Transitions:
  - RESET -> RUN when rst=0.
  - RUN -> HALT on halt_req. The current instruction is not accepted and not counted; the PC holds it for re-presentation after resume.
  - HALT -> RUN on resume. inst_valid=1 the next cycle, with the held PC.
  - halt_req and resume together in RUN: halt wins. In HALT: resume wins.
  - Redirect in HALT updates PC; the FSM stays in HALT.
  - Redirect together with halt_req: PC takes the target, then HALT.
- Accept: inst_valid and not stall and not redirect and not halt_req. On accept, fetch_count +1, wrapping at 2^CNT_W.
- Stall: inst_code and inst_pc are held stable by re-issuing the same rom_addr; no counting.
- Reset mid-operation (any state, any inputs): on the next edge all state returns to RESET values. Redirect, halt and stall inputs are ignored while rst=1.
- inst_pc[31:ADDR_W+2] is hard zero.

Test Plan:
- Reset, then run 5 cycles with ROM word i = 0x1000_0000+i → inst_pc 0x00,0x04,…,0x10; inst_code matches; inst_valid=1 from the first cycle after rst; fetch_count=5.
- Free-run from 0xF8 (ADDR_W=6) → sequence 0xF8, 0xFC, 0x00; fetch_count keeps incrementing.
- Stall for 3 cycles while inst_pc=0x08 → inst_pc/inst_code held at 0x08; count unchanged; 0x0C appears the cycle after stall drops.
- At inst_pc=0x10, br_offset=-2 → next inst_pc=0x0C. At 0x10, jmp_target=0x20 together with br_taken → next inst_pc=0x80 (jmp wins). Redirect during stall → target presented next cycle, stalled instruction not counted.
- halt_req at inst_pc=0x14 → halted=1, inst_valid=0, rom_addr=5 held. Jump to 0x40 while halted → still halted. resume → inst_valid=1 with inst_pc=0x40.
- Assert rst for 1 cycle mid-stall during HALT → next cycle inst_pc=RESET_PC, fetch_count=0, halted=0, and RUN resumes the following cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses a 1-cycle synchronous ROM and
// presents PC-aligned instructions to decode with stall, redirect and halt handling.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              jmp,
  input  logic [25:0]       jmp_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       inst_code,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int unsigned PW = ADDR_W + 2;

  typedef enum logic [1:0] {StReset, StRun, StHalt} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pc_q, npc, pc_inc;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      br_off_ext, br_target32, jmp_target32, pc_ext;
  logic             redirect, accept;

  assign pc_ext       = {{(32-PW){1'b0}}, pc_q};
  assign pc_inc       = pc_q + PW'(4);
  assign br_off_ext   = {{14{br_offset[15]}}, br_offset, 2'b00};
  assign br_target32  = pc_ext + 32'd4 + br_off_ext;
  assign jmp_target32 = {4'b0000, jmp_target, 2'b00};

  assign inst_valid = (state_q == StRun);
  assign halted     = (state_q == StHalt);
  assign redirect   = jmp | br_taken;
  assign accept     = inst_valid & ~stall & ~redirect & ~halt_req;

  // The PC always names the word currently on rom_data, so holding means re-issuing the PC.
  always_comb begin
    npc = pc_inc;
    if (rst) begin
      npc = RESET_PC[PW-1:0];
    end else if (jmp) begin
      npc = jmp_target32[PW-1:0];
    end else if (br_taken) begin
      npc = br_target32[PW-1:0];
    end else if ((state_q != StRun) || halt_req || stall) begin
      npc = pc_q;
    end
  end

  assign rom_addr = npc[PW-1:2];

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = StReset;
    end else begin
      unique case (state_q)
        StReset: state_d = StRun;
        StRun:   if (halt_req) state_d = StHalt;
        StHalt:  if (resume) state_d = StRun;
        default: state_d = StReset;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReset;
      pc_q    <= RESET_PC[PW-1:0];
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= npc;
      if (accept) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign inst_code   = rom_data;
  assign inst_pc     = pc_ext;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer with a behavioural 1-cycle ROM; expectations are
// queued as each vector is driven and popped when the outputs are sampled.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp, halt_req, resume;
  logic [15:0] br_offset;
  logic [25:0] jmp_target;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data, inst_code, inst_pc;
  logic        inst_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] rom [64];

  typedef struct {
    logic        rst, stall, br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] tgt;
    logic        halt, res;
    logic [7:0]  e_pc;
    logic        e_valid, e_halted;
    logic [15:0] e_cnt;
    logic [5:0]  e_raddr;
  } vec_t;

  typedef struct {
    logic [31:0] pc, code;
    logic        valid, halted;
    logic [15:0] cnt;
    logic [5:0]  raddr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_applied = 0;
  int   n_miss    = 0;
  bit   done      = 1'b0;

  fetch_sequencer #(.ADDR_W(6), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .halt_req    (halt_req),
    .resume      (resume),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .inst_code   (inst_code),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #100000;
    if (!done) begin
      n_miss++;
      $display("FAIL timeout: wait expired after %0d vectors", n_applied);
      $finish;
    end
  end

  task automatic add(input logic r, input logic s, input logic b, input logic [15:0] off,
                     input logic j, input logic [25:0] tgt, input logic h, input logic rs,
                     input logic [7:0] pc, input logic v, input logic hl,
                     input logic [15:0] cnt, input logic [5:0] ra);
    vec_t t;
    t.rst = r; t.stall = s; t.br = b; t.off = off; t.jmp = j; t.tgt = tgt;
    t.halt = h; t.res = rs; t.e_pc = pc; t.e_valid = v; t.e_halted = hl;
    t.e_cnt = cnt; t.e_raddr = ra;
    vecs.push_back(t);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;

    //  rst st br off       jmp tgt    hlt res   pc    val hlt cnt raddr
    add(1, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h00, 0, 0, 0,  6'h00);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h00, 0, 0, 0,  6'h00);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h00, 1, 0, 0,  6'h01);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h04, 1, 0, 1,  6'h02);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h08, 1, 0, 2,  6'h03);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h0C, 1, 0, 3,  6'h04);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h10, 1, 0, 4,  6'h05);
    add(0, 0, 0, 16'h0,    1, 26'h2,  0, 0,     8'h14, 1, 0, 5,  6'h02);
    // stall three cycles at 0x08
    add(0, 1, 0, 16'h0,    0, 26'h0,  0, 0,     8'h08, 1, 0, 5,  6'h02);
    add(0, 1, 0, 16'h0,    0, 26'h0,  0, 0,     8'h08, 1, 0, 5,  6'h02);
    add(0, 1, 0, 16'h0,    0, 26'h0,  0, 0,     8'h08, 1, 0, 5,  6'h02);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h08, 1, 0, 5,  6'h03);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h0C, 1, 0, 6,  6'h04);
    // backward branch, then jmp beating branch, then redirect during stall
    add(0, 0, 1, 16'hFFFE, 0, 26'h0,  0, 0,     8'h10, 1, 0, 7,  6'h03);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h0C, 1, 0, 7,  6'h04);
    add(0, 0, 1, 16'h5,    1, 26'h20, 0, 0,     8'h10, 1, 0, 8,  6'h20);
    add(0, 1, 0, 16'h0,    0, 26'h0,  0, 0,     8'h80, 1, 0, 8,  6'h20);
    add(0, 1, 1, 16'h3,    0, 26'h0,  0, 0,     8'h80, 1, 0, 8,  6'h24);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h90, 1, 0, 8,  6'h25);
    // sequential wrap at the top of the address space, and branch wrap below zero
    add(0, 0, 0, 16'h0,    1, 26'h3E, 0, 0,     8'h94, 1, 0, 9,  6'h3E);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'hF8, 1, 0, 9,  6'h3F);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'hFC, 1, 0, 10, 6'h00);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h00, 1, 0, 11, 6'h01);
    add(0, 0, 1, 16'hFFFD, 0, 26'h0,  0, 0,     8'h04, 1, 0, 12, 6'h3F);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'hFC, 1, 0, 12, 6'h00);
    // halt at 0x14, jump while halted, resume
    add(0, 0, 0, 16'h0,    1, 26'h5,  0, 0,     8'h00, 1, 0, 13, 6'h05);
    add(0, 0, 0, 16'h0,    0, 26'h0,  1, 0,     8'h14, 1, 0, 13, 6'h05);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h14, 0, 1, 13, 6'h05);
    add(0, 0, 0, 16'h0,    1, 26'h10, 0, 0,     8'h14, 0, 1, 13, 6'h10);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 1,     8'h40, 0, 1, 13, 6'h10);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h40, 1, 0, 13, 6'h11);
    // halt+resume together: halt wins in RUN, resume wins in HALT
    add(0, 0, 0, 16'h0,    0, 26'h0,  1, 1,     8'h44, 1, 0, 14, 6'h11);
    add(0, 0, 0, 16'h0,    0, 26'h0,  1, 1,     8'h44, 0, 1, 14, 6'h11);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h44, 1, 0, 14, 6'h12);
    // redirect with halt, stall in HALT, reset overriding everything
    add(0, 0, 0, 16'h0,    1, 26'h8,  1, 0,     8'h48, 1, 0, 15, 6'h08);
    add(0, 1, 0, 16'h0,    0, 26'h0,  0, 0,     8'h20, 0, 1, 15, 6'h08);
    add(1, 1, 0, 16'h0,    1, 26'h3,  0, 1,     8'h20, 0, 1, 15, 6'h00);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h00, 0, 0, 0,  6'h00);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h00, 1, 0, 0,  6'h01);
    add(0, 0, 0, 16'h0,    0, 26'h0,  0, 0,     8'h04, 1, 0, 1,  6'h02);

    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_offset = '0; jmp = 1'b0;
    jmp_target = '0; halt_req = 1'b0; resume = 1'b0;
    @(posedge clk);
    #1;
    if (inst_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'h0 ||
        inst_pc !== 32'h0) begin
      n_miss++;
      $display("FAIL reset state: valid=%b halted=%b cnt=%0d pc=%h",
               inst_valid, halted, fetch_count, inst_pc);
    end

    for (int k = 0; k < vecs.size(); k++) begin
      exp_t e, g;
      @(negedge clk);
      rst = vecs[k].rst; stall = vecs[k].stall; br_taken = vecs[k].br;
      br_offset = vecs[k].off; jmp = vecs[k].jmp; jmp_target = vecs[k].tgt;
      halt_req = vecs[k].halt; resume = vecs[k].res;
      e.pc     = {24'h0, vecs[k].e_pc};
      e.code   = 32'h1000_0000 + {26'h0, vecs[k].e_pc[7:2]};
      e.valid  = vecs[k].e_valid;
      e.halted = vecs[k].e_halted;
      e.cnt    = vecs[k].e_cnt;
      e.raddr  = vecs[k].e_raddr;
      sb.push_back(e);
      #1;
      g.pc = inst_pc; g.code = inst_code; g.valid = inst_valid; g.halted = halted;
      g.cnt = fetch_count; g.raddr = rom_addr;
      e = sb.pop_front();
      n_applied++;
      if (g.pc !== e.pc || g.code !== e.code || g.valid !== e.valid ||
          g.halted !== e.halted || g.cnt !== e.cnt || g.raddr !== e.raddr) begin
        n_miss++;
        $display("FAIL vec%0d got/exp: pc=%h/%h code=%h/%h valid=%b/%b",
                 k, g.pc, e.pc, g.code, e.code, g.valid, e.valid);
        $display("  halted=%b/%b cnt=%0d/%0d raddr=%h/%h",
                 g.halted, e.halted, g.cnt, e.cnt, g.raddr, e.raddr);
      end
    end

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    if (n_miss == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
